uart_tx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_gen.sv | 40 ++++
 rtl/uart_tx_frame.sv | 153 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART serial stages: FSM state encoding,
// 8N1 framing constants and the default frame sync byte.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DONE
    } uart_state_e;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART stages: counts 0..CLKS_PER_BIT-1 while
// enabled and flags the last cycle of every bit period with o_tick.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign o_tick = i_en && (cnt_q == CNT_LAST);

    // Next count: clear wins, otherwise advance and wrap at the end of a bit.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = o_tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART 8N1 frame transmitter: optionally sends a sync header, then pulls
// FRAME_LEN payload bytes from the upstream buffer with a one-cycle
// request/valid handshake and serialises them LSB first on o_tx.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 104,
    parameter int          FRAME_LEN    = 9,
    parameter int          SEND_HEADER  = 1,
    parameter logic [7:0]  HEADER       = DEFAULT_HEADER
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_next,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [3:0] BYTE_LAST = 4'(FRAME_LEN);

    uart_state_e state_q, state_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        next_q, next_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        baud_en;
    logic        baud_tick;

    // The bit timer only runs while a bit is on the line; it sits at zero
    // otherwise so every start bit begins a full period.
    assign baud_en = (state_q == ST_START) || (state_q == ST_DATA) ||
                     (state_q == ST_STOP);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (!baud_en),
        .i_en    (baud_en),
        .o_tick  (baud_tick)
    );

    // Next-state logic; outputs are derived from the next state so they
    // appear registered in the same cycle the state is entered.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (SEND_HEADER != 0) begin
                        shift_d = HEADER;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_valid) begin
                    shift_d    = i_data;
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (byte_cnt_q == BYTE_LAST) ? ST_DONE : ST_REQ;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                byte_cnt_d = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tx_d   = (state_d == ST_START) ? 1'b0 :
                 (state_d == ST_DATA)  ? shift_d[0] : 1'b1;
        next_d = (state_d == ST_REQ);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs; reset forces the line idle-high at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            next_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            next_q     <= next_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_tx   = tx_q;
    assign o_next = next_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: stimulus pushes expected bytes,
// per-DUT line decoders pop and compare whole 10-bit frames.
module tb_uart_tx_frame;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n;

    // DUT0: header on, 9-byte frames
    logic       start0, valid0, next0, tx0, busy0, done0;
    logic [7:0] data0;
    logic       up_en, up_valid, spur_valid;
    logic [7:0] up_data;
    int         up_idx;

    // DUT1: no header, single-byte frames
    logic       start1, valid1, next1, tx1, busy1, done1;
    logic [7:0] data1;

    logic [7:0] exp0[$];
    logic [7:0] exp1[$];

    int total = 0;
    int bad   = 0;
    int next_cnt0 = 0, next_cnt1 = 0, done_cnt0 = 0, done_cnt1 = 0;

    assign valid0 = up_valid | spur_valid;
    assign data0  = spur_valid ? 8'hFF : up_data;

    always #5 clk = ~clk;

    uart_tx_frame #(
        .CLKS_PER_BIT (CPB),
        .FRAME_LEN    (9),
        .SEND_HEADER  (1),
        .HEADER       (8'hA5)
    ) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start0),
        .i_data  (data0),
        .i_valid (valid0),
        .o_next  (next0),
        .o_tx    (tx0),
        .o_busy  (busy0),
        .o_done  (done0)
    );

    uart_tx_frame #(
        .CLKS_PER_BIT (CPB),
        .FRAME_LEN    (1),
        .SEND_HEADER  (0),
        .HEADER       (8'hA5)
    ) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start1),
        .i_data  (data1),
        .i_valid (valid1),
        .o_next  (next1),
        .o_tx    (tx1),
        .o_busy  (busy1),
        .o_done  (done1)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Pulse i_start on one DUT for a single clock; optionally log the header.
    task automatic applyStimulus(input int which, input bit push_header);
        @(posedge clk);
        #1;
        if (push_header) exp0.push_back(8'hA5);
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Sample 10 bits of CPB cycles each, starting at the current negedge.
    task automatic decodeFrame(input int which, output logic [9:0] word,
                               output bit stable, output bit aborted);
        logic cur;
        word = '0;
        stable = 1'b1;
        aborted = 1'b0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (!(b == 0 && c == 0)) @(negedge clk);
                if (!rst_n) begin
                    aborted = 1'b1;
                    return;
                end
                cur = (which == 0) ? tx0 : tx1;
                if (c == 0) word[b] = cur;
                else if (cur !== word[b]) stable = 1'b0;
            end
        end
    endtask

    // Wait for o_done on a DUT; check it is a clean pulse ending the busy period.
    task automatic waitDone(input int which, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (((which == 0) ? done0 : done1) === 1'b1) seen = 1'b1;
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            checkOutput("busy_during_done", 32'((which == 0) ? busy0 : busy1), 32'd1);
            @(negedge clk);
            checkOutput("done_single_cycle", 32'((which == 0) ? done0 : done1), 32'd0);
            checkOutput("busy_after_done", 32'((which == 0) ? busy0 : busy1), 32'd0);
        end
    endtask

    // Pulse counters for o_next / o_done on both DUTs.
    initial begin
        forever begin
            @(negedge clk);
            if (next0 === 1'b1) next_cnt0++;
            if (next1 === 1'b1) next_cnt1++;
            if (done0 === 1'b1) done_cnt0++;
            if (done1 === 1'b1) done_cnt1++;
        end
    end

    // Upstream buffer model for DUT0: answer each o_next one cycle later.
    initial begin
        up_idx = 0;
        up_valid = 1'b0;
        up_data = 8'h00;
        forever begin
            @(negedge clk);
            if (up_en && rst_n && next0 === 1'b1) begin
                @(posedge clk);
                #1;
                up_data = 8'((up_idx % 9) + 1);
                exp0.push_back(up_data);
                up_idx++;
                up_valid = 1'b1;
                @(posedge clk);
                #1;
                up_valid = 1'b0;
            end
        end
    end

    // Line decoder / scoreboard for DUT0.
    initial begin
        logic [9:0] word;
        logic [7:0] e;
        bit stable, aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx0 === 1'b0) begin
                decodeFrame(0, word, stable, aborted);
                if (!aborted) begin
                    if (exp0.size() == 0) begin
                        checkOutput("dut0_unexpected_frame", 32'(word), 32'h0);
                    end else begin
                        e = exp0.pop_front();
                        checkOutput("dut0_frame", 32'(word), 32'({1'b1, e, 1'b0}));
                        checkOutput("dut0_bit_hold", 32'(stable), 32'd1);
                    end
                end
            end
        end
    end

    // Line decoder / scoreboard for DUT1.
    initial begin
        logic [9:0] word;
        logic [7:0] e;
        bit stable, aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx1 === 1'b0) begin
                decodeFrame(1, word, stable, aborted);
                if (!aborted) begin
                    if (exp1.size() == 0) begin
                        checkOutput("dut1_unexpected_frame", 32'(word), 32'h0);
                    end else begin
                        e = exp1.pop_front();
                        checkOutput("dut1_frame", 32'(word), 32'({1'b1, e, 1'b0}));
                        checkOutput("dut1_bit_hold", 32'(stable), 32'd1);
                    end
                end
            end
        end
    end

    // Main directed sequence.
    initial begin
        int base_next, base_done;
        bit seen;

        rst_n = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        valid1 = 1'b0;
        data1 = 8'h00;
        up_en = 1'b0;
        spur_valid = 1'b0;

        // reset idle
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", 32'(tx0), 32'd1);
        checkOutput("reset_busy", 32'(busy0), 32'd0);
        checkOutput("reset_next", 32'(next0), 32'd0);
        checkOutput("reset_done", 32'(done0), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checkOutput("idle_tx", 32'(tx0), 32'd1);
            checkOutput("idle_busy", 32'(busy0), 32'd0);
            checkOutput("idle_next", 32'(next0), 32'd0);
        end

        // header only, upstream silent
        $display("[TB] header only");
        base_next = next_cnt0;
        applyStimulus(0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (next0 === 1'b1) seen = 1'b1;
        end
        checkOutput("hdr_next_seen", 32'(seen), 32'd1);
        repeat (20) @(negedge clk);
        checkOutput("hdr_wait_tx", 32'(tx0), 32'd1);
        checkOutput("hdr_wait_busy", 32'(busy0), 32'd1);
        checkOutput("hdr_next_pulses", 32'(next_cnt0 - base_next), 32'd1);
        checkOutput("hdr_queue_empty", 32'(exp0.size()), 32'd0);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // full frame with spurious valid and start
        $display("[TB] full frame");
        up_en = 1'b1;
        base_next = next_cnt0;
        base_done = done_cnt0;
        applyStimulus(0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (next0 === 1'b1) seen = 1'b1;
        end
        checkOutput("frame_first_next", 32'(seen), 32'd1);
        @(posedge clk);
        repeat (6) @(posedge clk);
        #1 spur_valid = 1'b1;
        @(posedge clk);
        #1 spur_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        waitDone(0, 2000);
        repeat (5) @(negedge clk);
        checkOutput("frame_next_pulses", 32'(next_cnt0 - base_next), 32'd9);
        checkOutput("frame_done_pulses", 32'(done_cnt0 - base_done), 32'd1);
        checkOutput("frame_queue_empty", 32'(exp0.size()), 32'd0);
        checkOutput("frame_tx_idle", 32'(tx0), 32'd1);

        // async reset during header data bit 3
        $display("[TB] reset mid-frame");
        up_en = 1'b0;
        applyStimulus(0, 1'b0);
        repeat (17) @(posedge clk);
        #2;
        checkOutput("bit3_tx_low", 32'(tx0), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_tx", 32'(tx0), 32'd1);
        checkOutput("async_reset_busy", 32'(busy0), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        up_en = 1'b1;
        base_next = next_cnt0;
        applyStimulus(0, 1'b1);
        waitDone(0, 2000);
        repeat (5) @(negedge clk);
        checkOutput("restart_next_pulses", 32'(next_cnt0 - base_next), 32'd9);
        checkOutput("restart_queue_empty", 32'(exp0.size()), 32'd0);
        up_en = 1'b0;

        // no header, single-byte frame
        $display("[TB] no-header single byte");
        base_next = next_cnt1;
        base_done = done_cnt1;
        applyStimulus(1, 1'b0);
        @(negedge clk);
        checkOutput("nohdr_next_now", 32'(next1), 32'd1);
        @(posedge clk);
        #1;
        exp1.push_back(8'h3C);
        data1 = 8'h3C;
        valid1 = 1'b1;
        @(posedge clk);
        #1;
        valid1 = 1'b0;
        data1 = 8'h00;
        waitDone(1, 200);
        repeat (3) @(negedge clk);
        checkOutput("nohdr_next_pulses", 32'(next_cnt1 - base_next), 32'd1);
        checkOutput("nohdr_done_pulses", 32'(done_cnt1 - base_done), 32'd1);
        checkOutput("nohdr_queue_empty", 32'(exp1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
